// File: rtl/hash_mem_responder.sv
// Word RAM plus start/done sequencer serving the SHA-256 hasher's memory port.
// Define HASH_MEM_WRITE_PROTECT_EN to block hasher writes that fall outside the output window.
module hash_mem_responder #(
    parameter int DEPTH      = 256,
    parameter int NUM_NONCES = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [15:0] cfg_message_addr,
    input  logic [15:0] cfg_output_addr,
    input  logic        host_en,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        start,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        done,
    input  logic        mem_clk,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        busy,
    output logic        complete,
    output logic [4:0]  result_count,
    output logic        err_range,
    output logic        err_window,
    output logic        err_host,
    output logic        err_timeout,
    output logic [1:0]  state_dbg
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [16:0] DEPTH17   = 17'(DEPTH);
    localparam logic [16:0] NONCES17  = 17'(NUM_NONCES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
`ifdef HASH_MEM_WRITE_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FINISH} state_t;
    state_t state;
    assign state_dbg = state;

    logic [31:0]   ram [DEPTH];
    logic [TW-1:0] tmo_cnt;

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_clk};

    logic mem_in_range, host_in_range, in_window;
    assign mem_in_range  = {1'b0, mem_addr} < DEPTH17;
    assign host_in_range = {1'b0, host_addr} < DEPTH17;
    // 17-bit window bounds so a window near 0xFFFF does not wrap to low addresses
    assign in_window = ({1'b0, mem_addr} >= {1'b0, output_addr}) &&
                       ({1'b0, mem_addr} <  ({1'b0, output_addr} + NONCES17));

    // Single write port: host owns it in IDLE, hasher in RUN
    logic          ram_we;
    logic [IW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = host_addr[IW-1:0];
        ram_wdata = host_wdata;
        if (state == S_IDLE && host_en && host_we && host_in_range) begin
            ram_we = 1'b1;
        end else if (state == S_RUN && mem_we && mem_in_range && (in_window || !PROTECT)) begin
            ram_we    = 1'b1;
            ram_waddr = mem_addr[IW-1:0];
            ram_wdata = mem_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            start         <= 1'b0;
            complete      <= 1'b0;
            busy          <= 1'b0;
            message_addr  <= '0;
            output_addr   <= '0;
            result_count  <= '0;
            err_range     <= 1'b0;
            err_window    <= 1'b0;
            err_host      <= 1'b0;
            err_timeout   <= 1'b0;
            tmo_cnt       <= '0;
            host_rdata    <= '0;
            mem_read_data <= '0;
        end else begin
            mem_read_data <= mem_in_range ? ram[mem_addr[IW-1:0]] : 32'd0;
            case (state)
                S_IDLE: begin
                    if (host_en && !host_we)
                        host_rdata <= host_in_range ? ram[host_addr[IW-1:0]] : 32'd0;
                    if (host_en && host_we && !host_in_range)
                        err_range <= 1'b1;
                    if (go) begin
                        message_addr <= cfg_message_addr;
                        output_addr  <= cfg_output_addr;
                        result_count <= '0;
                        tmo_cnt      <= '0;
                        err_range    <= 1'b0;
                        err_window   <= 1'b0;
                        err_host     <= 1'b0;
                        err_timeout  <= 1'b0;
                        start        <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    if (host_en) err_host <= 1'b1;
                    start <= 1'b0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (host_en)       err_host  <= 1'b1;
                    if (!mem_in_range) err_range <= 1'b1;
                    if (mem_we) begin
                        if (!in_window)               err_window   <= 1'b1;
                        else if (result_count != 5'd31) result_count <= result_count + 5'd1;
                    end
                    // done takes precedence over an expiring timeout
                    if (done) begin
                        complete <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_FINISH;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        complete    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    complete <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hash_mem_responder.sv
// Self-checking bench for hash_mem_responder (DEPTH=256, NUM_NONCES=16, TIMEOUT=100).
module tb_hash_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic [15:0] cfg_message_addr = '0, cfg_output_addr = '0;
    logic        host_en = 1'b0, host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [31:0] host_rdata;
    logic        start;
    logic [15:0] message_addr, output_addr;
    logic        done = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic [31:0] mem_read_data;
    logic        busy, complete;
    logic [4:0]  result_count;
    logic        err_range, err_window, err_host, err_timeout;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [256];
    logic [31:0] exp_v;
    int n;

    hash_mem_responder #(.DEPTH(256), .NUM_NONCES(16), .TIMEOUT(100)) dut (
        .clk(clk), .reset_n(reset_n), .go(go),
        .cfg_message_addr(cfg_message_addr), .cfg_output_addr(cfg_output_addr),
        .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .start(start), .message_addr(message_addr), .output_addr(output_addr),
        .done(done), .mem_clk(clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy), .complete(complete), .result_count(result_count),
        .err_range(err_range), .err_window(err_window), .err_host(err_host),
        .err_timeout(err_timeout), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks: inputs change and outputs are sampled 1 time unit after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        if (a < 16'd256) model[a[7:0]] = d;
        tick();
        host_en = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read_drive(input logic [15:0] a);
        host_en = 1'b1; host_we = 1'b0; host_addr = a;
        exp_q.push_back((a < 16'd256) ? model[a[7:0]] : 32'd0);
        tick();
        host_en = 1'b0;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [31:0] d, input bit commits);
        mem_we = 1'b1; mem_addr = a; mem_write_data = d;
        if (commits) model[a[7:0]] = d;
        tick();
        mem_we = 1'b0; mem_addr = 16'd0;
    endtask

    task automatic launch(input logic [15:0] m, input logic [15:0] o);
        cfg_message_addr = m; cfg_output_addr = o; go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({start, complete, busy, err_range, err_window, err_host, err_timeout} !== 7'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {start, complete, busy, err_range, err_window, err_host, err_timeout});
        end
        checks++;
        if ({result_count, host_rdata, mem_read_data, message_addr, output_addr} !== '0) begin
            errors++;
            $display("FAIL reset_values: count %0d hr %h mr %h ma %h oa %h required all 0",
                     result_count, host_rdata, mem_read_data, message_addr, output_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_host_load();
        for (int i = 0; i < 20; i++) host_write(16'(i), 32'h0100_0000 + 32'(i));
        host_read_drive(16'd5);
        exp_v = exp_q.pop_front();
        checks++;
        if (host_rdata !== exp_v || exp_v !== 32'h0100_0005) begin
            errors++;
            $display("FAIL host_readback: got %h required %h", host_rdata, 32'h0100_0005);
        end
    endtask

    task automatic test_run_handshake();
        launch(16'd0, 16'h0020);
        checks++;
        if (start !== 1'b1 || busy !== 1'b1 || output_addr !== 16'h0020) begin
            errors++;
            $display("FAIL start_pulse: start %b busy %b oa %h required 1 1 0020", start, busy, output_addr);
        end
        mem_addr = 16'd3;
        exp_q.push_back(model[3]);
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (start !== 1'b0 || mem_read_data !== exp_v) begin
            errors++;
            $display("FAIL mem_read: start %b data %h required 0 %h", start, mem_read_data, exp_v);
        end
        for (int i = 0; i < 16; i++) mem_write(16'h0020 + 16'(i), $urandom, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (complete !== 1'b1 || busy !== 1'b0 || result_count !== 5'd16) begin
            errors++;
            $display("FAIL run_finish: complete %b busy %b count %0d required 1 0 16", complete, busy, result_count);
        end
        tick();
        checks++;
        if (complete !== 1'b0) begin
            errors++;
            $display("FAIL complete_width: got %b required 0", complete);
        end
        host_read_drive(16'h002F);
        exp_v = exp_q.pop_front();
        checks++;
        if (host_rdata !== exp_v) begin
            errors++;
            $display("FAIL result_readback: got %h required %h", host_rdata, exp_v);
        end
        checks++;
        if ({err_range, err_window, err_host, err_timeout} !== 4'd0) begin
            errors++;
            $display("FAIL clean_run_errs: got %b required 0000", {err_range, err_window, err_host, err_timeout});
        end
    endtask

    task automatic test_window_violation();
        bit commits;
`ifdef HASH_MEM_WRITE_PROTECT_EN
        commits = 1'b0;
`else
        commits = 1'b1;
`endif
        host_write(16'h0040, 32'h55AA_0040);
        launch(16'd0, 16'h0020);
        tick();
        mem_write(16'h0040, 32'hDEAD_BEEF, commits);
        mem_write(16'h0020, 32'h1111_0020, 1'b1);
        mem_write(16'h002F, 32'h1111_002F, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (err_window !== 1'b1 || result_count !== 5'd2 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL window_err: win %b count %0d range %b required 1 2 0", err_window, result_count, err_range);
        end
        tick();
        host_read_drive(16'h0040);
        exp_v = exp_q.pop_front();
        checks++;
        if (host_rdata !== exp_v) begin
            errors++;
            $display("FAIL window_ram: got %h required %h", host_rdata, exp_v);
        end
    endtask

    task automatic test_host_collision_range();
        launch(16'd0, 16'h0020);
        tick();
        host_en = 1'b1; host_we = 1'b1; host_addr = 16'd5; host_wdata = 32'hBAD0_BAD0;
        tick();
        host_en = 1'b0; host_we = 1'b0;
        checks++;
        if (err_host !== 1'b1 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL host_collision: host %b range %b required 1 0", err_host, err_range);
        end
        mem_addr = 16'h0100;
        tick();
        mem_addr = 16'd0;
        checks++;
        if (mem_read_data !== 32'd0 || err_range !== 1'b1) begin
            errors++;
            $display("FAIL range_read: data %h range %b required 0 1", mem_read_data, err_range);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        host_read_drive(16'd5);
        exp_v = exp_q.pop_front();
        checks++;
        if (host_rdata !== exp_v) begin
            errors++;
            $display("FAIL host_blocked_ram: got %h required %h", host_rdata, exp_v);
        end
    endtask

    task automatic test_timeout();
        launch(16'd0, 16'h0020);
        tick();
        n = 0;
        while (complete !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 100 || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout: cycles %0d err %b required 100 1", n, err_timeout);
        end
        tick();
        launch(16'd0, 16'h0020);
        tick();
        repeat (99) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (complete !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_precedence: complete %b err %b required 1 0", complete, err_timeout);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        launch(16'd0, 16'h0020);
        tick();
        mem_write(16'h0021, 32'h2222_0021, 1'b1);
        mem_write(16'h0022, 32'h2222_0022, 1'b1);
        #2;
        reset_n = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || start !== 1'b0 || result_count !== 5'd0 || complete !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy %b start %b count %0d complete %b required 0 0 0 0",
                     busy, start, result_count, complete);
        end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (start !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_idle: start %b busy %b state %0d required 0 0 0", start, busy, state_dbg);
        end
        host_read_drive(16'h0022);
        exp_v = exp_q.pop_front();
        checks++;
        if (host_rdata !== exp_v) begin
            errors++;
            $display("FAIL ram_survives_reset: got %h required %h", host_rdata, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_run_handshake();
        test_window_violation();
        test_host_collision_range();
        test_timeout();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
